// File: rtl/vcdc_pkg.sv
// vcdc_pkg: shared types and helpers for the cascaded reversible counter.
//   DIGIT_W      width of one counter digit
//   digit_t      one digit value
//   digit_max    largest legal digit value for a radix
//   clamp_digit  limits a loaded digit to the legal range for a radix
package vcdc_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] digit_t;

   function automatic digit_t digit_max(input int unsigned radix);
      return DIGIT_W'(radix - 1);
   endfunction

   function automatic digit_t clamp_digit(input digit_t d, input int unsigned radix);
      if (32'(d) >= radix) return digit_max(radix);
      return d;
   endfunction

endpackage

// File: rtl/vcdc_digit.sv
// vcdc_digit: one reversible modulo-RADIX digit with synchronous load.
//   clk   in   rising-edge clock
//   s     in   asynchronous active-high reset (digit -> 0)
//   en    in   count enable for this digit
//   up    in   1 = increment, 0 = decrement
//   ld    in   synchronous load, wins over en
//   d     in   load value, clamped to RADIX-1
//   q     out  registered digit value
//   term  out  digit is at its terminal value for the current direction
module vcdc_digit
   import vcdc_pkg::*;
#(
   parameter int unsigned RADIX = 10
) (
   input  logic   clk,
   input  logic   s,
   input  logic   en,
   input  logic   up,
   input  logic   ld,
   input  digit_t d,
   output digit_t q,
   output logic   term
);

   localparam digit_t DMAX = digit_max(RADIX);

   digit_t r_q;

   // Terminal follows up with no latency so the ripple chain sees direction flips at once.
   always_comb begin
      term = 1'b0;
      if (up) term = (r_q == DMAX);
      else    term = (r_q == '0);
   end

   // Priority: reset, load, count.
   always_ff @(posedge clk or posedge s) begin
      if (s) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= clamp_digit(d, RADIX);
      end else if (en) begin
         if (up) r_q <= term ? '0   : r_q + DIGIT_W'(1);
         else    r_q <= term ? DMAX : r_q - DIGIT_W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/vcdc_bcd_chain.sv
// vcdc_bcd_chain: DIGITS cascaded reversible digits of programmable radix.
// Optional feature macro: VCDC_HOLD_AT_TC_EN (adds input hold; saturate instead of wrap).
//   clk   in   rising-edge clock
//   s     in   asynchronous active-high reset (Q -> 0, ovf -> 0)
//   ce    in   count enable
//   up    in   1 = increment, 0 = decrement
//   ld    in   synchronous parallel load (clears ovf, suppresses counting)
//   din   in   load value, digit i at [4i+3:4i]
//   hold  in   (VCDC_HOLD_AT_TC_EN only) saturate at terminal count
//   Q     out  counter value, digit i at [4i+3:4i]
//   TC    out  terminal count for current direction (combinational)
//   CEO   out  cascade enable out = ce & TC & ~ld (combinational)
//   ovf   out  sticky wrap flag
module vcdc_bcd_chain
   import vcdc_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned RADIX  = 10
) (
   input  logic                      clk,
   input  logic                      s,
   input  logic                      ce,
   input  logic                      up,
   input  logic                      ld,
   input  logic [DIGITS*DIGIT_W-1:0] din,
`ifdef VCDC_HOLD_AT_TC_EN
   input  logic                      hold,
`endif
   output logic [DIGITS*DIGIT_W-1:0] Q,
   output logic                      TC,
   output logic                      CEO,
   output logic                      ovf
);

   logic [DIGITS-1:0] w_term;
   logic [DIGITS-1:0] w_en;
   logic              w_sat;
   logic              r_ovf;

   // Saturation only matters on the edge that would otherwise wrap.
`ifdef VCDC_HOLD_AT_TC_EN
   assign w_sat = hold & CEO;
`else
   assign w_sat = 1'b0;
`endif

   assign TC  = &w_term;
   assign CEO = ce & TC & ~ld;

   // Ripple enable: a digit counts when every lower digit is at its terminal.
   always_comb begin
      w_en    = '0;
      w_en[0] = ce & ~w_sat;
      for (int i = 1; i < int'(DIGITS); i++) begin
         w_en[i] = w_en[i-1] & w_term[i-1];
      end
   end

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
      vcdc_digit #(.RADIX(RADIX)) u_digit (
         .clk  (clk),
         .s    (s),
         .en   (w_en[g]),
         .up   (up),
         .ld   (ld),
         .d    (din[g*DIGIT_W +: DIGIT_W]),
         .q    (Q[g*DIGIT_W +: DIGIT_W]),
         .term (w_term[g])
      );
   end

   // Sticky wrap flag, cleared only by reset or load.
   always_ff @(posedge clk or posedge s) begin
      if (s) begin
         r_ovf <= 1'b0;
      end else if (ld) begin
         r_ovf <= 1'b0;
      end else if (CEO && !w_sat) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;

endmodule

// File: tb/tb_vcdc_bcd_chain.sv
// tb_vcdc_bcd_chain: directed checks of vcdc_bcd_chain with DIGITS=3, RADIX=10.
// Build with VCDC_HOLD_AT_TC_EN defined to also exercise the hold feature.
module tb_vcdc_bcd_chain;

   localparam int unsigned DIGITS = 3;
   localparam int unsigned RADIX  = 10;
   localparam int unsigned W      = DIGITS * 4;

   logic         clk = 1'b0;
   logic         s   = 1'b1;
   logic         ce  = 1'b0;
   logic         up  = 1'b1;
   logic         ld  = 1'b0;
   logic [W-1:0] din = '0;
`ifdef VCDC_HOLD_AT_TC_EN
   logic         hold = 1'b0;
`endif
   logic [W-1:0] Q;
   logic         TC;
   logic         CEO;
   logic         ovf;

   int n_tests = 0;
   int n_fail  = 0;

   vcdc_bcd_chain #(.DIGITS(DIGITS), .RADIX(RADIX)) dut (
      .clk  (clk),
      .s    (s),
      .ce   (ce),
      .up   (up),
      .ld   (ld),
      .din  (din),
`ifdef VCDC_HOLD_AT_TC_EN
      .hold (hold),
`endif
      .Q    (Q),
      .TC   (TC),
      .CEO  (CEO),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [W-1:0] v);
      ld  = 1'b1;
      din = v;
      tick();
      ld  = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_q",   32'(Q),   32'h000);
      check("rst_ovf", 32'(ovf), 32'h0);
      check("rst_tc_up", 32'(TC), 32'h0);
      tick();
      s = 1'b0;

      // Async reset in the middle of counting.
      load(12'h121);
      ce = 1'b1; up = 1'b1;
      tick(); tick();
      check("cnt_123", 32'(Q), 32'h123);
      s = 1'b1;
      #1;
      check("async_q",   32'(Q),   32'h000);
      check("async_ovf", 32'(ovf), 32'h0);
      #1;
      s = 1'b0;
      tick();
      check("resume_001", 32'(Q), 32'h001);

      // Carry ripple through two digits.
      ce = 1'b0;
      load(12'h099);
      ce = 1'b1;
      #1;
      check("ripple_tc_pre",  32'(TC),  32'h0);
      check("ripple_ceo_pre", 32'(CEO), 32'h0);
      tick();
      check("ripple_q",    32'(Q),   32'h100);
      check("ripple_tc",   32'(TC),  32'h0);
      check("ripple_ceo",  32'(CEO), 32'h0);

      // Up wrap, ovf sticky.
      ce = 1'b0;
      load(12'h999);
      check("load_ovf", 32'(ovf), 32'h0);
      ce = 1'b1;
      #1;
      check("upwrap_tc",  32'(TC),  32'h1);
      check("upwrap_ceo", 32'(CEO), 32'h1);
      tick();
      check("upwrap_q",   32'(Q),   32'h000);
      check("upwrap_ovf", 32'(ovf), 32'h1);
      tick(); tick();
      check("upwrap_q2",   32'(Q),   32'h002);
      check("upwrap_ovf2", 32'(ovf), 32'h1);

      // Down wrap from reset, then direction flip.
      ce = 1'b0;
      s  = 1'b1;
      #1;
      check("rst2_ovf", 32'(ovf), 32'h0);
      s  = 1'b0;
      up = 1'b0;
      ce = 1'b1;
      #1;
      check("dn_tc",  32'(TC),  32'h1);
      check("dn_ceo", 32'(CEO), 32'h1);
      tick();
      check("dnwrap_q",   32'(Q),   32'h999);
      check("dnwrap_ovf", 32'(ovf), 32'h1);
      up = 1'b1;
      #1;
      check("flip_tc", 32'(TC), 32'h1);

      // Load priority over count, clamp of out-of-range digit.
      ld  = 1'b1;
      din = 12'h1F7;
      #1;
      check("ld_ceo", 32'(CEO), 32'h0);
      tick();
      ld = 1'b0;
      check("clamp_q",   32'(Q),   32'h197);
      check("clamp_ovf", 32'(ovf), 32'h0);

      // Borrow ripple going down.
      ce = 1'b0;
      load(12'h100);
      up = 1'b0;
      ce = 1'b1;
      tick();
      check("borrow_q", 32'(Q), 32'h099);

      // Idle: nothing active, state holds.
      ce = 1'b0;
      tick(); tick();
      check("idle_q",   32'(Q),   32'h099);
      check("idle_ovf", 32'(ovf), 32'h0);

`ifdef VCDC_HOLD_AT_TC_EN
      // Saturate at all-nines while hold is set.
      load(12'h999);
      up   = 1'b1;
      ce   = 1'b1;
      hold = 1'b1;
      tick(); tick(); tick();
      check("hold_q",   32'(Q),   32'h999);
      check("hold_ceo", 32'(CEO), 32'h1);
      check("hold_ovf", 32'(ovf), 32'h0);
      hold = 1'b0;
      tick();
      check("unhold_q",   32'(Q),   32'h000);
      check("unhold_ovf", 32'(ovf), 32'h1);
      // Hold has no effect away from terminal count.
      hold = 1'b1;
      tick();
      check("hold_noeff_q", 32'(Q), 32'h001);
      hold = 1'b0;
      ce   = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
